// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions used by the E-stage multiply/divide unit.
//   MDU_OP_W     : width of the decoded MDU op field carried in the D->E register
//   MDU_*        : op encodings (values outside 0..8 behave like MDU_NONE)
//   mdu_state_e  : MDU timer state, IDLE when the countdown is zero, RUN otherwise
//   mdu_is_start : true for the long-latency ops that arm the countdown
package mips_defs;

  localparam int MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] MDU_NONE  = 4'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd5;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd6;
  localparam logic [MDU_OP_W-1:0] MDU_MFHI  = 4'd7;
  localparam logic [MDU_OP_W-1:0] MDU_MFLO  = 4'd8;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic mdu_is_start(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit.
// Owns the architectural HI/LO registers and emulates a fixed-latency
// multiplier/divider: the result is computed at start, parked in pending
// registers, and copied into HI/LO when a countdown reaches its last cycle.
// Ports:
//   clk      : clock, all state updates on posedge
//   reset    : synchronous, active-high; clears HI/LO, countdown and pending result
//   MDUOpE   : decoded MDU op from the D->E register (see mips_defs)
//   A, B     : forwarded rs / rt operands
//   Start    : combinational, current op is mult/multu/div/divu
//   Busy     : combinational, Start or countdown running; drives the D-stage stall
//   MDUOutE  : combinational, HI for MFHI, LO for MFLO, otherwise 0
//   HI, LO   : architectural HI/LO
module e_mdu
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MDU_OP_W-1:0] MDUOpE,
  input  logic [31:0]         A,
  input  logic [31:0]         B,
  output logic                Start,
  output logic                Busy,
  output logic [31:0]         MDUOutE,
  output logic [31:0]         HI,
  output logic [31:0]         LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;
  logic [31:0]   pend_hi_reg, pend_hi_next;
  logic [31:0]   pend_lo_reg, pend_lo_next;
  logic          pend_valid_reg, pend_valid_next;

  mdu_state_e    state;

  logic signed [63:0] prod_signed;
  logic [63:0]        prod_unsigned;
  logic [31:0]        div_b;
  logic signed [31:0] quot_signed, rem_signed;
  logic [31:0]        quot_unsigned, rem_unsigned;
  logic [31:0]        result_hi, result_lo;
  logic               result_valid;
  logic               is_div;

  assign state = (cnt_reg != '0) ? MDU_RUN : MDU_IDLE;

  // Arithmetic datapath. Operands are sign/zero extended to 64 bits so the
  // full product is produced directly.
  assign prod_signed   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_unsigned = {32'b0, A} * {32'b0, B};

  // A zero divisor never commits, so substitute 1 to keep the divider
  // outputs defined instead of X.
  assign div_b         = (B == 32'd0) ? 32'd1 : B;
  assign quot_signed   = $signed(A) / $signed(div_b);
  assign rem_signed    = $signed(A) % $signed(div_b);
  assign quot_unsigned = A / div_b;
  assign rem_unsigned  = A % div_b;

  assign is_div = (MDUOpE == MDU_DIV) || (MDUOpE == MDU_DIVU);

  always_comb begin
    result_hi    = '0;
    result_lo    = '0;
    result_valid = 1'b0;
    case (MDUOpE)
      MDU_MULT: begin
        {result_hi, result_lo} = prod_signed;
        result_valid           = 1'b1;
      end
      MDU_MULTU: begin
        {result_hi, result_lo} = prod_unsigned;
        result_valid           = 1'b1;
      end
      MDU_DIV: begin
        result_lo    = quot_signed;
        result_hi    = rem_signed;
        result_valid = (B != 32'd0);
      end
      MDU_DIVU: begin
        result_lo    = quot_unsigned;
        result_hi    = rem_unsigned;
        result_valid = (B != 32'd0);
      end
      default: ;
    endcase
  end

  // Next-state logic. Ops are only honoured in IDLE; while RUN the only
  // activity is the countdown and the commit on its final cycle.
  always_comb begin
    cnt_next        = cnt_reg;
    hi_next         = hi_reg;
    lo_next         = lo_reg;
    pend_hi_next    = pend_hi_reg;
    pend_lo_next    = pend_lo_reg;
    pend_valid_next = pend_valid_reg;

    case (state)
      MDU_IDLE: begin
        if (Start) begin
          pend_hi_next    = result_hi;
          pend_lo_next    = result_lo;
          pend_valid_next = result_valid;
          cnt_next        = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (MDUOpE == MDU_MTHI) begin
          hi_next = A;
        end else if (MDUOpE == MDU_MTLO) begin
          lo_next = A;
        end
      end
      MDU_RUN: begin
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1) && pend_valid_reg) begin
          hi_next = pend_hi_reg;
          lo_next = pend_lo_reg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg        <= '0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      pend_hi_reg    <= '0;
      pend_lo_reg    <= '0;
      pend_valid_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      hi_reg         <= hi_next;
      lo_reg         <= lo_next;
      pend_hi_reg    <= pend_hi_next;
      pend_lo_reg    <= pend_lo_next;
      pend_valid_reg <= pend_valid_next;
    end
  end

  assign Start = mdu_is_start(MDUOpE);
  assign Busy  = Start | (cnt_reg != '0);

  always_comb begin
    MDUOutE = '0;
    case (MDUOpE)
      MDU_MFHI: MDUOutE = hi_reg;
      MDU_MFLO: MDUOutE = lo_reg;
      default:  ;
    endcase
  end

  assign HI = hi_reg;
  assign LO = lo_reg;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases followed by randomized ops,
// compared against a reference model that derives results with magnitude
// arithmetic and tracks HI/LO plus the expected busy length per op.
module tb_e_mdu;
  import mips_defs::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        start_o, busy_o;
  logic [31:0] out_o, hi_o, lo_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .MDUOpE(op), .A(a), .B(b),
    .Start(start_o), .Busy(busy_o), .MDUOutE(out_o), .HI(hi_o), .LO(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Product from operand magnitudes, sign applied afterwards.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input bit sgn);
    logic [63:0] mx, my, p;
    bit nx, ny;
    nx = sgn && x[31];
    ny = sgn && y[31];
    mx = nx ? (64'd4294967296 - {32'b0, x}) : {32'b0, x};
    my = ny ? (64'd4294967296 - {32'b0, y}) : {32'b0, y};
    p  = mx * my;
    if (nx != ny) p = -p;
    return p;
  endfunction

  // Returns {remainder, quotient}; truncation toward zero, remainder follows dividend.
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input bit sgn);
    logic [63:0] mx, my, q, r;
    bit nx, ny;
    if (y == 32'd0) return 64'd0;
    nx = sgn && x[31];
    ny = sgn && y[31];
    mx = nx ? (64'd4294967296 - {32'b0, x}) : {32'b0, x};
    my = ny ? (64'd4294967296 - {32'b0, y}) : {32'b0, y};
    q  = mx / my;
    r  = mx % my;
    if (nx != ny) q = -q;
    if (nx) r = -r;
    return {r[31:0], q[31:0]};
  endfunction

  // Long-latency op: check Busy length, HI/LO held while running, result after.
  task automatic run_long(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    bit wr;
    int n, cycles;
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    r = '0; wr = 1'b1; n = MC;
    case (o)
      MDU_MULT:  r = ref_mul(x, y, 1'b1);
      MDU_MULTU: r = ref_mul(x, y, 1'b0);
      MDU_DIV:   begin r = ref_div(x, y, 1'b1); wr = (y != 0); n = DC; end
      default:   begin r = ref_div(x, y, 1'b0); wr = (y != 0); n = DC; end
    endcase
    @(negedge clk);
    op = o; a = x; b = y;
    #1;
    check_value("start", 64'(start_o), 64'd1);
    cycles = 0;
    while (busy_o === 1'b1 && cycles < 60) begin
      cycles++;
      check_value("hold_hi", 64'(hi_o), 64'(old_hi));
      check_value("hold_lo", 64'(lo_o), 64'(old_lo));
      @(negedge clk);
      op = MDU_NONE;
      #1;
    end
    check_value("busy_cycles", 64'(cycles), 64'(n + 1));
    if (wr) {m_hi, m_lo} = r;
    check_value("res_hi", 64'(hi_o), 64'(m_hi));
    check_value("res_lo", 64'(lo_o), 64'(m_lo));
    $display("op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", o, x, y, cycles, hi_o, lo_o);
  endtask

  task automatic do_move(input logic [3:0] o, input logic [31:0] x);
    @(negedge clk);
    op = o; a = x; b = $urandom;
    #1;
    check_value("move_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    op = MDU_NONE;
    #1;
    if (o == MDU_MTHI) m_hi = x; else m_lo = x;
    check_value("move_hi", 64'(hi_o), 64'(m_hi));
    check_value("move_lo", 64'(lo_o), 64'(m_lo));
    $display("op=%0d a=%h hi=%h lo=%h", o, x, hi_o, lo_o);
  endtask

  // MFHI/MFLO, NONE and undefined encodings: no state change, read path only.
  task automatic do_quiet(input logic [3:0] o);
    logic [31:0] exp_out;
    exp_out = (o == MDU_MFHI) ? m_hi : (o == MDU_MFLO) ? m_lo : 32'd0;
    @(negedge clk);
    op = o; a = $urandom; b = $urandom;
    #1;
    check_value("quiet_out", 64'(out_o), 64'(exp_out));
    check_value("quiet_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    op = MDU_NONE;
    #1;
    check_value("quiet_hi", 64'(hi_o), 64'(m_hi));
    check_value("quiet_lo", 64'(lo_o), 64'(m_lo));
    $display("op=%0d out=%h hi=%h lo=%h", o, exp_out, hi_o, lo_o);
  endtask

  initial begin
    int cycles, kind;
    logic [31:0] x, y;
    reset = 1'b1; op = MDU_NONE; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_value("rst_hi", 64'(hi_o), 64'd0);
    check_value("rst_lo", 64'(lo_o), 64'd0);
    check_value("rst_busy", 64'(busy_o), 64'd0);
    check_value("rst_start", 64'(start_o), 64'd0);
    check_value("rst_out", 64'(out_o), 64'd0);

    // Directed examples with literal expectations.
    run_long(MDU_MULT, 32'hFFFFFFFD, 32'h00000005);
    check_value("t1_hi", 64'(hi_o), 64'h00000000FFFFFFFF);
    check_value("t1_lo", 64'(lo_o), 64'h00000000FFFFFFF1);
    run_long(MDU_DIV, 32'hFFFFFFF9, 32'h00000002);
    check_value("t2_lo", 64'(lo_o), 64'h00000000FFFFFFFD);
    check_value("t2_hi", 64'(hi_o), 64'h00000000FFFFFFFF);
    run_long(MDU_DIVU, 32'hFFFFFFF9, 32'h00000002);
    check_value("t2u_lo", 64'(lo_o), 64'h000000007FFFFFFC);
    check_value("t2u_hi", 64'(hi_o), 64'h0000000000000001);
    do_move(MDU_MTHI, 32'h12345678);
    do_quiet(MDU_MFHI);
    check_value("t3_hi", 64'(hi_o), 64'h0000000012345678);

    do_move(MDU_MTHI, 32'hAAAAAAAA);
    do_move(MDU_MTLO, 32'hAAAAAAAA);
    run_long(MDU_DIV, 32'h00001234, 32'h00000000);
    check_value("t4_hi", 64'(hi_o), 64'h00000000AAAAAAAA);
    check_value("t4_lo", 64'(lo_o), 64'h00000000AAAAAAAA);

    // Protocol violation injected on purpose: MULT and MTLO issued while running.
    $display("note: injecting MULT and MTLO while unit is running");
    cycles = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      case (k)
        0:       begin op = MDU_MULT; a = 32'd3;   b = 32'd7;   end
        2:       begin op = MDU_MULT; a = 32'd100; b = 32'd100; end
        3:       begin op = MDU_MTLO; a = 32'hDEADBEEF; end
        default: op = MDU_NONE;
      endcase
      #1;
      if (k == 4) check_value("run_mtlo_ignored", 64'(lo_o), 64'(m_lo));
      if (busy_o !== 1'b1) break;
      cycles++;
    end
    check_value("t6_busy", 64'(cycles), 64'(MC + 1));
    m_hi = 32'd0; m_lo = 32'd21;
    check_value("t6_hi", 64'(hi_o), 64'(m_hi));
    check_value("t6_lo", 64'(lo_o), 64'(m_lo));
    $display("op=%0d violation case busy=%0d hi=%h lo=%h", MDU_MULT, cycles, hi_o, lo_o);

    // Reset in the middle of a MULTU.
    @(negedge clk);
    op = MDU_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk);
    op = MDU_NONE;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    check_value("t5_hi", 64'(hi_o), 64'd0);
    check_value("t5_lo", 64'(lo_o), 64'd0);
    check_value("t5_busy", 64'(busy_o), 64'd0);
    repeat (12) @(negedge clk);
    #1;
    check_value("t5_late_hi", 64'(hi_o), 64'd0);
    check_value("t5_late_lo", 64'(lo_o), 64'd0);
    $display("op=%0d reset mid-run hi=%h lo=%h", MDU_MULTU, hi_o, lo_o);

    // Randomized ops.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 12);
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) y = 32'(y[7:0]);
      if (x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd1;
      case (kind)
        0:       run_long(MDU_MULT, x, y);
        1:       run_long(MDU_MULTU, x, y);
        2:       run_long(MDU_DIV, x, y);
        3:       run_long(MDU_DIVU, x, y);
        4:       do_move(MDU_MTHI, x);
        5:       do_move(MDU_MTLO, x);
        6:       do_quiet(MDU_MFHI);
        7:       do_quiet(MDU_MFLO);
        8:       do_quiet(MDU_NONE);
        default: do_quiet(4'($urandom_range(9, 15)));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
